mw_wb_control: RTL and testbench

//  Parametrised MW->WB control unit: registers MW-stage decode into writeback controls
//  (enable, dest addr, data-source select) and tracks one in-flight multi-cycle mult/div.

---
 rtl/mw_wb_control_pkg.sv | 48 ++++
 rtl/mw_wb_control_md_tracker.sv | 91 +++++++++
 rtl/mw_wb_control.sv | 173 +++++++++++++++++
 tb/tb_mw_wb_control.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mw_wb_control_pkg.sv
// Shared constants for the MW->WB control slice: opcodes, ALU ops, writeback selects,
// status codes and the mult/div tracker states.
package mw_wb_control_pkg;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_J    = 5'd1;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JAL  = 5'd3;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;
  localparam logic [4:0] OP_SETX = 5'd21;
  localparam logic [4:0] OP_BEX  = 5'd22;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  localparam logic [2:0] EXC_NONE = 3'd0;
  localparam logic [2:0] EXC_ADD  = 3'd1;
  localparam logic [2:0] EXC_ADDI = 3'd2;
  localparam logic [2:0] EXC_SUB  = 3'd3;
  localparam logic [2:0] EXC_MUL  = 3'd4;
  localparam logic [2:0] EXC_DIV  = 3'd5;

  typedef enum logic [2:0] {
    WB_ALU    = 3'd0,
    WB_MEM    = 3'd1,
    WB_PC1    = 3'd2,
    WB_MD     = 3'd3,
    WB_TARGET = 3'd4,
    WB_EXC    = 3'd5
  } wb_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE  = 2'd0,
    MD_BUSY  = 2'd1,
    MD_WRITE = 2'd2
  } md_state_e;

  function automatic logic is_md_aluop(input logic [4:0] aluop);
    return (aluop == ALU_MUL) || (aluop == ALU_DIV);
  endfunction

endpackage

// File: rtl/mw_wb_control_md_tracker.sv
// Tracks one in-flight mult/div: IDLE/BUSY/WRITE FSM, timeout counter,
// latched destination register and mul/div type.
module mw_md_tracker
  import mw_wb_control_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OPCODE_W   = 5,
  parameter int REG_W      = 5,
  parameter int MD_TIMEOUT = 40
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              md_start_i,
  input  logic [DATA_W-1:0] md_insn_i,
  input  logic              md_ready_i,
  output logic              busy_o,
  output logic              accept_o,
  output logic              start_stall_o,
  output logic [REG_W-1:0]  rd_o,
  output logic              is_div_o,
  output logic              timeout_err_o
);

  localparam int CNT_W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             div_q, div_d;
  logic             tmo_q, tmo_d;
  logic             take;

  logic unused_md_insn;
  assign unused_md_insn = ^md_insn_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    div_d   = div_q;
    tmo_d   = 1'b0;
    take    = 1'b0;
    case (state_q)
      MD_IDLE:  take = md_start_i;
      MD_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (md_ready_i) begin
          state_d = MD_WRITE;
        end else if (cnt_q == CNT_W'(MD_TIMEOUT - 1)) begin
          state_d = MD_IDLE;
          tmo_d   = 1'b1;
        end
      end
      MD_WRITE: begin
        state_d = MD_IDLE;
        take    = md_start_i;
      end
      default:  state_d = MD_IDLE;
    endcase
    if (take) begin
      state_d = MD_BUSY;
      cnt_d   = '0;
      rd_d    = md_insn_i[DATA_W-OPCODE_W-1 -: REG_W];
      div_d   = (md_insn_i[6:2] == ALU_DIV);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      div_q   <= div_d;
      tmo_q   <= tmo_d;
    end
  end

  assign busy_o        = (state_q != MD_IDLE);
  assign accept_o      = (state_q == MD_BUSY) && md_ready_i;
  assign start_stall_o = (state_q == MD_BUSY) && md_start_i;
  assign rd_o          = rd_q;
  assign is_div_o      = div_q;
  assign timeout_err_o = tmo_q;

endmodule

// File: rtl/mw_wb_control.sv
// MW->WB control: decodes the MW instruction into registered regfile write controls and
// arbitrates the write port with the mult/div result. Optional: MW_EXC_STATUS_EN.
module mw_wb_control
  import mw_wb_control_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int OPCODE_W   = 5,
  parameter int REG_W      = 5,
  parameter int LINK_REG   = 31,
  parameter int STATUS_REG = 30,
  parameter int MD_TIMEOUT = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mw_valid,
  input  logic [DATA_W-1:0] mw_insn,
  input  logic              alu_ovf,
  input  logic              md_start,
  input  logic [DATA_W-1:0] md_insn,
  input  logic              md_ready,
  input  logic              md_exception,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_addr,
  output logic [2:0]        wb_sel,
  output logic [2:0]        status_code,
  output logic              md_busy,
  output logic              stall_req,
  output logic              md_timeout_err
);

  logic [OPCODE_W-1:0] mw_op;
  logic [REG_W-1:0]    mw_rd;
  logic [4:0]          mw_aluop;
  logic                mw_we, mw_wr;
  logic [REG_W-1:0]    mw_addr;
  wb_sel_e             mw_sel;
  logic [2:0]          mw_code;

  logic                md_accept, md_start_stall, md_div;
  logic [REG_W-1:0]    md_rd;
  logic                md_we;
  logic [REG_W-1:0]    md_addr;
  wb_sel_e             md_sel;
  logic [2:0]          md_code;

  logic                wb_en_q, wb_en_d;
  logic [REG_W-1:0]    wb_addr_q, wb_addr_d;
  wb_sel_e             wb_sel_q, wb_sel_d;
  logic [2:0]          wb_code_q, wb_code_d;

  logic unused_in;
  assign unused_in = ^{mw_insn, alu_ovf, md_exception};

  assign mw_op    = mw_insn[DATA_W-1 -: OPCODE_W];
  assign mw_rd    = mw_insn[DATA_W-OPCODE_W-1 -: REG_W];
  assign mw_aluop = mw_insn[6:2];

  always_comb begin
    mw_we   = 1'b0;
    mw_addr = mw_rd;
    mw_sel  = WB_ALU;
    mw_code = EXC_NONE;
    case (mw_op)
      OPCODE_W'(OP_ALU):  mw_we = !is_md_aluop(mw_aluop);
      OPCODE_W'(OP_ADDI): mw_we = 1'b1;
      OPCODE_W'(OP_LW): begin
        mw_we  = 1'b1;
        mw_sel = WB_MEM;
      end
      OPCODE_W'(OP_JAL): begin
        mw_we   = 1'b1;
        mw_addr = REG_W'(LINK_REG);
        mw_sel  = WB_PC1;
      end
      OPCODE_W'(OP_SETX): begin
        mw_we   = 1'b1;
        mw_addr = REG_W'(STATUS_REG);
        mw_sel  = WB_TARGET;
      end
      default: ;
    endcase
`ifdef MW_EXC_STATUS_EN
    if (alu_ovf && mw_op == OPCODE_W'(OP_ALU)) begin
      if (mw_aluop == ALU_ADD)      mw_code = EXC_ADD;
      else if (mw_aluop == ALU_SUB) mw_code = EXC_SUB;
    end else if (alu_ovf && mw_op == OPCODE_W'(OP_ADDI)) begin
      mw_code = EXC_ADDI;
    end
    if (mw_code != EXC_NONE) begin
      mw_we   = 1'b1;
      mw_addr = REG_W'(STATUS_REG);
      mw_sel  = WB_EXC;
    end
`endif
  end

  assign mw_wr = mw_valid && mw_we && (mw_addr != '0);

  mw_md_tracker #(
    .DATA_W    (DATA_W),
    .OPCODE_W  (OPCODE_W),
    .REG_W     (REG_W),
    .MD_TIMEOUT(MD_TIMEOUT)
  ) u_md_tracker (
    .clk_i        (clock),
    .rst_i        (reset),
    .md_start_i   (md_start),
    .md_insn_i    (md_insn),
    .md_ready_i   (md_ready),
    .busy_o       (md_busy),
    .accept_o     (md_accept),
    .start_stall_o(md_start_stall),
    .rd_o         (md_rd),
    .is_div_o     (md_div),
    .timeout_err_o(md_timeout_err)
  );

  always_comb begin
    md_we   = (md_rd != '0);
    md_addr = md_rd;
    md_sel  = WB_MD;
    md_code = EXC_NONE;
`ifdef MW_EXC_STATUS_EN
    if (md_exception) begin
      md_we   = 1'b1;
      md_addr = REG_W'(STATUS_REG);
      md_sel  = WB_EXC;
      md_code = md_div ? EXC_DIV : EXC_MUL;
    end
`endif
  end

  // A stalled MW instruction is held upstream, so it is written only once the stall drops.
  assign stall_req = (md_accept && mw_wr) || md_start_stall;

  always_comb begin
    wb_en_d   = 1'b0;
    wb_addr_d = '0;
    wb_sel_d  = WB_ALU;
    wb_code_d = EXC_NONE;
    if (md_accept) begin
      wb_en_d   = md_we;
      wb_addr_d = md_addr;
      wb_sel_d  = md_sel;
      wb_code_d = md_code;
    end else if (mw_wr && !stall_req) begin
      wb_en_d   = 1'b1;
      wb_addr_d = mw_addr;
      wb_sel_d  = mw_sel;
      wb_code_d = mw_code;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_sel_q  <= WB_ALU;
      wb_code_q <= EXC_NONE;
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_sel_q  <= wb_sel_d;
      wb_code_q <= wb_code_d;
    end
  end

  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_sel      = wb_sel_q;
  assign status_code = wb_code_q;

endmodule

// File: tb/tb_mw_wb_control.sv
// Directed bench for mw_wb_control: vector table for MW decode plus hand sequences
// for the mult/div tracker, arbitration, timeout and reset corners.
module tb_mw_wb_control;
  import mw_wb_control_pkg::*;

`ifdef MW_EXC_STATUS_EN
  localparam bit EXC = 1'b1;
`else
  localparam bit EXC = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset, mw_valid, alu_ovf, md_start, md_ready, md_exception;
  logic [31:0] mw_insn, md_insn;
  logic        wb_en, md_busy, stall_req, md_timeout_err;
  logic [4:0]  wb_addr;
  logic [2:0]  wb_sel, status_code;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mw_wb_control #(
    .DATA_W(32), .OPCODE_W(5), .REG_W(5), .LINK_REG(31), .STATUS_REG(30), .MD_TIMEOUT(40)
  ) dut (
    .clock(clock), .reset(reset), .mw_valid(mw_valid), .mw_insn(mw_insn), .alu_ovf(alu_ovf),
    .md_start(md_start), .md_insn(md_insn), .md_ready(md_ready), .md_exception(md_exception),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_sel(wb_sel), .status_code(status_code),
    .md_busy(md_busy), .stall_req(stall_req), .md_timeout_err(md_timeout_err)
  );

  typedef struct {
    string      name;
    logic       valid;
    logic [31:0] insn;
    logic       ovf;
    logic       en;
    logic [4:0] addr;
    logic [2:0] sel;
    logic [2:0] code;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                      input logic [4:0] aluop);
    return {op, rd, 15'h2a5a, aluop, 2'b01};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add_vec(input string name, input logic valid, input logic [31:0] insn,
                         input logic ovf, input logic en, input logic [4:0] addr,
                         input logic [2:0] sel, input logic [2:0] code);
    vec_t v;
    v.name = name; v.valid = valid; v.insn = insn; v.ovf = ovf;
    v.en = en; v.addr = addr; v.sel = sel; v.code = code;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen_write;

    reset = 1'b1; mw_valid = 1'b0; mw_insn = '0; alu_ovf = 1'b0;
    md_start = 1'b0; md_insn = '0; md_ready = 1'b0; md_exception = 1'b0;

    add_vec("addi_r3",    1, ins(OP_ADDI, 5'd3, 5'd0),     0, 1, 5'd3,  3'd0, 3'd0);
    add_vec("jal",        1, ins(OP_JAL, 5'd9, 5'd0),      0, 1, 5'd31, 3'd2, 3'd0);
    add_vec("add_rd0",    1, ins(OP_ALU, 5'd0, ALU_ADD),   0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("lw_r9",      1, ins(OP_LW, 5'd9, 5'd0),       0, 1, 5'd9,  3'd1, 3'd0);
    add_vec("setx",       1, ins(OP_SETX, 5'd4, 5'd0),     0, 1, 5'd30, 3'd4, 3'd0);
    add_vec("sub_r12",    1, ins(OP_ALU, 5'd12, ALU_SUB),  0, 1, 5'd12, 3'd0, 3'd0);
    add_vec("sw",         1, ins(OP_SW, 5'd4, 5'd0),       0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("bne",        1, ins(OP_BNE, 5'd6, 5'd0),      0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("j",          1, ins(OP_J, 5'd6, 5'd0),        0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("jr",         1, ins(OP_JR, 5'd6, 5'd0),       0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("blt",        1, ins(OP_BLT, 5'd6, 5'd0),      0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("bex",        1, ins(OP_BEX, 5'd6, 5'd0),      0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("addi_inval", 0, ins(OP_ADDI, 5'd3, 5'd0),     0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("mw_mul",     1, ins(OP_ALU, 5'd7, ALU_MUL),   0, 0, 5'd0,  3'd0, 3'd0);
    add_vec("add_ovf",    1, ins(OP_ALU, 5'd4, ALU_ADD),   1, 1,
            EXC ? 5'd30 : 5'd4, EXC ? 3'd5 : 3'd0, EXC ? 3'd1 : 3'd0);
    add_vec("addi_ovf",   1, ins(OP_ADDI, 5'd8, 5'd0),     1, 1,
            EXC ? 5'd30 : 5'd8, EXC ? 3'd5 : 3'd0, EXC ? 3'd2 : 3'd0);
    add_vec("sub_ovf",    1, ins(OP_ALU, 5'd2, ALU_SUB),   1, 1,
            EXC ? 5'd30 : 5'd2, EXC ? 3'd5 : 3'd0, EXC ? 3'd3 : 3'd0);
    add_vec("lw_ovf",     1, ins(OP_LW, 5'd5, 5'd0),       1, 1, 5'd5,  3'd1, 3'd0);
    add_vec("addi0_ovf",  1, ins(OP_ADDI, 5'd0, 5'd0),     1, EXC,
            EXC ? 5'd30 : 5'd0, EXC ? 3'd5 : 3'd0, EXC ? 3'd2 : 3'd0);

    // Reset state
    repeat (3) tick();
    check("rst_wb_en", 32'(wb_en), 0);
    check("rst_wb_addr", 32'(wb_addr), 0);
    check("rst_wb_sel", 32'(wb_sel), 0);
    check("rst_status", 32'(status_code), 0);
    check("rst_busy", 32'(md_busy), 0);
    check("rst_tmo", 32'(md_timeout_err), 0);
    check("rst_stall", 32'(stall_req), 0);
    reset = 1'b0;
    tick();

    // MW decode vectors
    for (int i = 0; i < vecs.size(); i++) begin
      mw_valid = vecs[i].valid; mw_insn = vecs[i].insn; alu_ovf = vecs[i].ovf;
      #1 check({vecs[i].name, "_stall"}, 32'(stall_req), 0);
      tick();
      check({vecs[i].name, "_en"}, 32'(wb_en), 32'(vecs[i].en));
      if (vecs[i].en) begin
        check({vecs[i].name, "_addr"}, 32'(wb_addr), 32'(vecs[i].addr));
        check({vecs[i].name, "_sel"}, 32'(wb_sel), 32'(vecs[i].sel));
      end
      check({vecs[i].name, "_code"}, 32'(status_code), 32'(vecs[i].code));
    end
    mw_valid = 1'b0; alu_ovf = 1'b0;
    tick();

    // mult r7, ready 17 cycles after start
    md_insn = ins(OP_ALU, 5'd7, ALU_MUL); md_start = 1'b1;
    tick();
    md_start = 1'b0;
    check("mul_busy", 32'(md_busy), 1);
    repeat (16) tick();
    check("mul_busy_hold", 32'(md_busy), 1);
    check("mul_no_wb", 32'(wb_en), 0);
    md_ready = 1'b1;
    #1 check("mul_ready_stall", 32'(stall_req), 0);
    tick();
    md_ready = 1'b0;
    check("mul_wb_en", 32'(wb_en), 1);
    check("mul_wb_addr", 32'(wb_addr), 7);
    check("mul_wb_sel", 32'(wb_sel), 3);
    check("mul_write_busy", 32'(md_busy), 1);
    tick();
    check("mul_idle", 32'(md_busy), 0);
    check("mul_after_en", 32'(wb_en), 0);

    // md_ready coincident with lw r5 in MW
    md_insn = ins(OP_ALU, 5'd7, ALU_DIV); md_start = 1'b1;
    tick();
    md_start = 1'b0;
    repeat (5) tick();
    md_ready = 1'b1; mw_valid = 1'b1; mw_insn = ins(OP_LW, 5'd5, 5'd0);
    #1 check("conf_stall", 32'(stall_req), 1);
    tick();
    md_ready = 1'b0;
    check("conf_md_en", 32'(wb_en), 1);
    check("conf_md_addr", 32'(wb_addr), 7);
    check("conf_md_sel", 32'(wb_sel), 3);
    #1 check("conf_stall_drop", 32'(stall_req), 0);
    tick();
    check("conf_lw_en", 32'(wb_en), 1);
    check("conf_lw_addr", 32'(wb_addr), 5);
    check("conf_lw_sel", 32'(wb_sel), 1);
    mw_valid = 1'b0;
    tick();
    check("conf_done_en", 32'(wb_en), 0);

    // md_start while BUSY is refused
    md_insn = ins(OP_ALU, 5'd10, ALU_MUL); md_start = 1'b1;
    tick();
    md_insn = ins(OP_ALU, 5'd11, ALU_DIV);
    #1 check("busy_start_stall", 32'(stall_req), 1);
    tick();
    md_start = 1'b0;
    #1 check("busy_start_release", 32'(stall_req), 0);
    repeat (3) tick();
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    check("busy_keep_rd", 32'(wb_addr), 10);
    check("busy_keep_sel", 32'(wb_sel), 3);

    // md_start during WRITE is accepted
    md_insn = ins(OP_ALU, 5'd12, ALU_DIV); md_start = 1'b1;
    #1 check("write_start_stall", 32'(stall_req), 0);
    tick();
    md_start = 1'b0;
    check("write_restart_busy", 32'(md_busy), 1);
    check("write_restart_en", 32'(wb_en), 0);
    repeat (2) tick();
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    check("restart_addr", 32'(wb_addr), 12);
    tick();

    // Timeout after 40 BUSY cycles
    md_insn = ins(OP_ALU, 5'd7, ALU_MUL); md_start = 1'b1;
    tick();
    md_start = 1'b0;
    n = 0; seen_write = 1'b0;
    while (!md_timeout_err && n < 100) begin
      tick();
      n++;
      if (wb_en) seen_write = 1'b1;
    end
    check("tmo_cycles", 32'(n), 40);
    check("tmo_no_write", 32'(seen_write), 0);
    check("tmo_idle", 32'(md_busy), 0);
    tick();
    check("tmo_pulse_end", 32'(md_timeout_err), 0);

    // Spurious md_ready in IDLE
    md_ready = 1'b1;
    tick();
    md_ready = 1'b0;
    check("spur_en", 32'(wb_en), 0);
    check("spur_busy", 32'(md_busy), 0);

    // Reset while BUSY aborts silently
    md_insn = ins(OP_ALU, 5'd6, ALU_MUL); md_start = 1'b1;
    tick();
    md_start = 1'b0;
    repeat (4) tick();
    reset = 1'b1; md_ready = 1'b1;
    tick();
    reset = 1'b0; md_ready = 1'b0;
    check("rstb_busy", 32'(md_busy), 0);
    check("rstb_en", 32'(wb_en), 0);
    tick();
    check("rstb_en2", 32'(wb_en), 0);

    // div with md_exception
    md_insn = ins(OP_ALU, 5'd9, ALU_DIV); md_start = 1'b1;
    tick();
    md_start = 1'b0;
    repeat (3) tick();
    md_ready = 1'b1; md_exception = 1'b1;
    tick();
    md_ready = 1'b0; md_exception = 1'b0;
    check("divx_en", 32'(wb_en), 1);
    check("divx_addr", 32'(wb_addr), EXC ? 30 : 9);
    check("divx_sel", 32'(wb_sel), EXC ? 5 : 3);
    check("divx_code", 32'(status_code), EXC ? 5 : 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
